// File: rtl/adder_ternary_accum_seq.sv
// Packet reducer: folds two operands per beat into a running sum through one
// ternary adder, then holds the total until the consumer takes it.
module adder_ternary_accum_seq #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic [1:0]           in_keep,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 first_q, first_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 oovf_q, oovf_d;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     base;
    logic [WIDTH+1:0]     wide;
    logic                 beat_ovf;
    logic                 ovf_new;
    logic [1:0]           pop;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH:0]   cnt_wide;
    logic [CNT_WIDTH-1:0] cnt_new;

    // Datapath: first beat of a packet starts from zero instead of acc_q
    always_comb begin
        op_a     = in_keep[0] ? in0 : '0;
        op_b     = in_keep[1] ? in1 : '0;
        base     = first_q ? '0 : acc_q;
        wide     = {2'b00, base} + {2'b00, op_a} + {2'b00, op_b};
        beat_ovf = |wide[WIDTH+1:WIDTH];
        ovf_new  = (first_q ? 1'b0 : ovf_q) | beat_ovf;
        pop      = {1'b0, in_keep[0]} + {1'b0, in_keep[1]};
        cnt_base = first_q ? '0 : cnt_q;
        cnt_wide = {1'b0, cnt_base} + {{(CNT_WIDTH-1){1'b0}}, pop};
        cnt_new  = cnt_wide[CNT_WIDTH] ? '1 : cnt_wide[CNT_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        count_d   = count_q;
        oovf_d    = oovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = wide[WIDTH-1:0];
                    ovf_d   = ovf_new;
                    cnt_d   = cnt_new;
                    first_d = 1'b0;
                    if (in_last) begin
                        sum_d   = wide[WIDTH-1:0];
                        count_d = cnt_new;
                        oovf_d  = ovf_new;
                        first_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            first_q <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oovf_q  <= oovf_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = oovf_q;

endmodule

// File: tb/tb_adder_ternary_accum_seq.sv
// Bench for adder_ternary_accum_seq: directed packets with hand-computed
// totals pushed to a scoreboard that a monitor drains on each result handshake.
module tb_adder_ternary_accum_seq;

    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in0;
    logic [W-1:0]  in1;
    logic [1:0]    in_keep;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic [CW-1:0] count;
        logic          ovf;
    } res_t;

    res_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    adder_ternary_accum_seq #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic push(input logic [W-1:0] s, input logic [CW-1:0] c,
                        input logic o);
        res_t r;
        r.sum = s;
        r.count = c;
        r.ovf = o;
        exp_q.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] k, input logic l);
        int guard;
        in_valid = 1'b1;
        in0 = a;
        in1 = b;
        in_keep = k;
        in_last = l;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) $display("FAIL beat_timeout: in_ready stuck 0");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in0 = 'x;
        in1 = 'x;
        in_keep = 'x;
        in_last = 'x;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (out_valid) chk("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    // Monitor: a handshake completes on the next edge when both are high here
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_count", 32'(out_count), 32'(e.count));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in0 = '0;
        in1 = '0;
        in_keep = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);

        // 1: single beat, result held while out_ready low
        out_ready = 1'b0;
        push(8'd7, 16'd2, 1'b0);
        beat(8'd3, 8'd4, 2'b11, 1'b1);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_in_ready_hold", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drain();
        chk("t1_in_ready_after", 32'(in_ready), 32'd1);

        // 2: three back-to-back beats
        push(8'd210, 16'd6, 1'b0);
        beat(8'd10, 8'd20, 2'b11, 1'b0);
        beat(8'd30, 8'd40, 2'b11, 1'b0);
        beat(8'd50, 8'd60, 2'b11, 1'b1);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        drain();
        chk("t2_in_ready_after", 32'(in_ready), 32'd1);

        // 3: overflow, then sticky flag clears on the next packet
        push(8'd44, 16'd2, 1'b1);
        beat(8'd200, 8'd100, 2'b11, 1'b1);
        drain();
        push(8'd2, 16'd2, 1'b0);
        beat(8'd1, 8'd1, 2'b11, 1'b1);
        drain();

        // 4: keep masking, and an empty last beat
        push(8'd12, 16'd2, 1'b0);
        beat(8'd5, 8'd99, 2'b01, 1'b0);
        beat(8'd88, 8'd7, 2'b10, 1'b1);
        drain();
        push(8'd0, 16'd0, 1'b0);
        beat(8'd55, 8'd66, 2'b00, 1'b1);
        drain();

        // 5: backpressure with in_valid held high
        out_ready = 1'b0;
        push(8'd50, 16'd2, 1'b0);
        beat(8'd20, 8'd30, 2'b11, 1'b1);
        in_valid = 1'b1;
        in0 = 8'd77;
        in1 = 8'd77;
        in_keep = 2'b11;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_in_ready", 32'(in_ready), 32'd0);
            chk("t5_out_valid", 32'(out_valid), 32'd1);
            chk("t5_sum_stable", 32'(out_sum), 32'd50);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        push(8'd18, 16'd2, 1'b0);
        beat(8'd9, 8'd9, 2'b11, 1'b1);
        drain();

        // 6: reset mid-packet discards the partial sum
        beat(8'd100, 8'd100, 2'b11, 1'b0);
        beat(8'd50, 8'd0, 2'b11, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        push(8'd2, 16'd2, 1'b0);
        beat(8'd1, 8'd1, 2'b11, 1'b1);
        drain();

        // Reset in HOLD drops the pending result
        out_ready = 1'b0;
        beat(8'd4, 8'd4, 2'b11, 1'b1);
        chk("t7_out_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t7_out_valid", 32'(out_valid), 32'd0);
        chk("t7_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        push(8'd3, 16'd1, 1'b0);
        beat(8'd3, 8'd200, 2'b01, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adder_ternary_accum_seq.md
Name: adder_ternary_accum_seq

Overview:
- Sequencer that reduces a variable-length packet of operands to one sum, using a single shared ternary adder.
- The adder computes acc + in0 + in1 once per accepted beat; each beat supplies two operands.
- Input is a valid/ready stream delimited by a last flag; output is a held result with a valid/ready handshake.
- Sits between a producer of operand streams and any consumer of packet totals (e.g. checksum or histogram logic).

Parameters:
- WIDTH, 8, operand, accumulator and result width.
- CNT_WIDTH, 16, width of the kept-operand counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  block can accept a beat.
- in0  input  WIDTH  first operand of the beat.
- in1  input  WIDTH  second operand of the beat.
- in_keep  input  2  bit0 qualifies in0, bit1 qualifies in1; an unqualified operand is treated as 0.
- in_last  input  1  beat is the final beat of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  packet sum modulo 2^WIDTH.
- out_count  output  CNT_WIDTH  number of kept operands in the packet; saturates.
- out_ovf  output  1  sticky: the true sum exceeded 2^WIDTH-1 at any beat.

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst; rst has priority over all other activity in the same cycle.
- Beat transfer: in_valid && in_ready at a rising edge. Result transfer: out_valid && out_ready at a rising edge.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset values: state ACC, acc=0, first=1, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- ACC, on beat transfer:
  - Masked operands: a = in_keep[0] ? in0 : 0; b = in_keep[1] ? in1 : 0.
  - Base: 0 if first=1, otherwise acc.
  - Wide sum: s = base + a + b, computed at WIDTH+2 bits. acc <= s[WIDTH-1:0].
  - Overflow for the beat: s[WIDTH+1:WIDTH] != 0. ovf <= (first ? 0 : ovf) | beat overflow.
  - Count: cnt <= (first ? 0 : cnt) + popcount(in_keep), saturating at 2^CNT_WIDTH-1.
  - first <= 0.
  - If in_last: load out_sum, out_count and out_ovf with the new values; first <= 1; go to HOLD.
- Latency: out_valid rises on the cycle after the last beat is accepted. A packet of N beats occupies N cycles of ACC plus at least 1 cycle of HOLD.
- HOLD:
  - out_sum, out_count and out_ovf are held stable until result transfer.
  - On result transfer, return to ACC; in_ready=1 on the next cycle.
  - No input beat is accepted in the same cycle as the result handshake.
- A beat with in_keep=00 is legal. It adds 0 and does not change the count; if it is also last, the packet closes normally.
- A single-beat packet (in_last on the first beat) is legal.
- Idle gaps in ACC (in_valid=0) leave all state unchanged.
- Reset mid-packet discards the partial sum. Reset in HOLD drops the pending result (out_valid=0 on the next cycle).
- in0, in1, in_keep and in_last are ignored when no transfer occurs.

Test Plan:
1. Reset, then one beat in0=3, in1=4, keep=11, last=1 -> next cycle out_valid=1, out_sum=7, out_count=2, out_ovf=0; in_ready=0 until out_ready=1.
2. Three beats (10,20), (30,40), (50,60,last), all keep=11, back-to-back; out_ready=1 -> out_sum=210, out_count=6, out_ovf=0; in_ready=1 the cycle after the result handshake.
3. One beat (200,100), keep=11, last -> out_sum=44, out_ovf=1. The next packet (1,1,last) -> out_sum=2, out_ovf=0, showing the sticky flag clears per packet.
4. Beat (5,99) keep=01, then beat (88,7) keep=10 last -> out_sum=12, out_count=2. A separate beat with keep=00 last -> out_sum=0, out_count=0.
5. Result presented with out_ready held 0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no beats consumed. Raise out_ready -> handshake; the following packet (9,9,last) -> 18, with no carry-over from the previous packet.
6. Two beats (100,100), (50,0) accepted, then rst=1 for one cycle -> out_valid=0, in_ready=1. The next packet (1,1,last) -> out_sum=2, out_count=2, out_ovf=0.
